// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// State and size encodings plus the byte-merge helper.
package dmem_access_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    SZ_WORD = 1'b0,
    SZ_BYTE = 1'b1
  } size_t;

  typedef struct packed {
    logic  we;
    size_t size;
    logic  sgn;
  } req_ctl_t;

  function automatic logic [15:0] merge_byte(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_extend.sv
// Load-data byte/word select with sign or zero extension.
// Purely combinational; reusable by any load path.
import dmem_access_ctrl_pkg::*;

module dmem_load_extend #(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word,
  input  size_t             size,
  input  logic              sgn,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;

  assign sext = {{(DATA_W-8){word[7]}}, word[7:0]};
  assign zext = {{(DATA_W-8){1'b0}}, word[7:0]};

  // pick the full word or the extended low byte
  always_comb begin
    data = word;
    unique case (1'b1)
      (size == SZ_WORD):         data = word;
      (size == SZ_BYTE && sgn):  data = sext;
      (size == SZ_BYTE && !sgn): data = zext;
      default:                   data = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: single load/store requests to ren/wen cycles.
// Byte stores are merged by read-modify-write of the 16-bit word.
import dmem_access_ctrl_pkg::*;

module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state;
  state_t            nxt;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cap_hi_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged;

  assign merged = merge_byte(cap_hi_q, wdata_q[7:0]);
  assign rdata  = rdata_q;

  dmem_load_extend #(
    .DATA_W(DATA_W)
  ) u_ext (
    .word (mem_dout),
    .size (ctl_q.size),
    .sgn  (ctl_q.sgn),
    .data (ext_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // latch the request when it is accepted from idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && req) begin
      ctl_q.we   <= req_we;
      ctl_q.size <= req_byte ? SZ_BYTE : SZ_WORD;
      ctl_q.sgn  <= req_signed;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  // sample memory data only at the read exit, never while it is Z
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_hi_q <= '0;
      rdata_q  <= '0;
    end else if (state == S_READ) begin
      cap_hi_q <= mem_dout[DATA_W-1:8];
      if (!ctl_q.we) begin
        rdata_q <= ext_data;
      end
    end
  end

  // next state and state-decoded memory strobes
  always_comb begin
    nxt      = state;
    busy     = 1'b1;
    done     = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          nxt = (req_we && !req_byte) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        mem_ren  = 1'b1;
        mem_addr = addr_q;
        nxt      = ctl_q.we ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_wen  = 1'b1;
        mem_addr = addr_q;
        mem_din  = (ctl_q.size == SZ_BYTE) ? merged : wdata_q;
        nxt      = S_RESP;
      end
      S_RESP: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule
